// File: rtl/data_sram_if_pkg.sv
// Shared op codes, FSM encoding and small decode helpers for the data SRAM interface.
package data_sram_if_pkg;

  localparam logic [7:0] EXE_LB_OP  = 8'h20;
  localparam logic [7:0] EXE_LH_OP  = 8'h21;
  localparam logic [7:0] EXE_LW_OP  = 8'h23;
  localparam logic [7:0] EXE_LBU_OP = 8'h24;
  localparam logic [7:0] EXE_LHU_OP = 8'h25;
  localparam logic [7:0] EXE_SB_OP  = 8'h28;
  localparam logic [7:0] EXE_SH_OP  = 8'h29;
  localparam logic [7:0] EXE_SW_OP  = 8'h2B;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_CANCEL = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  function automatic logic is_load(input logic [7:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  // 0 = byte, 1 = half, 2 = word (bus size encoding)
  function automatic logic [1:0] op_size(input logic [7:0] op);
    case (op)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2'd1;
      EXE_LW_OP, EXE_SW_OP:             return 2'd2;
      default:                          return 2'd0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [7:0] op, input logic [1:0] off);
    case (op)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return off[0];
      EXE_LW_OP, EXE_SW_OP:             return off != 2'b00;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_sram_if_load_align.sv
// Combinational load lane select and sign/zero extension (little-endian lanes).
module load_align
  import data_sram_if_pkg::*;
(
  input  logic [7:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  logic [3:0][7:0] lanes;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  assign lanes    = raw;
  assign byte_sel = lanes[offset];
  assign half_sel = {lanes[{offset[1], 1'b1}], lanes[{offset[1], 1'b0}]};

  // Extend the selected lane(s) according to the load flavour.
  always_comb begin
    result = raw;
    case (op)
      EXE_LB_OP:  result = {{24{byte_sel[7]}}, byte_sel};
      EXE_LBU_OP: result = {24'h0, byte_sel};
      EXE_LH_OP:  result = {{16{half_sel[15]}}, half_sel};
      EXE_LHU_OP: result = {16'h0, half_sel};
      default:    result = raw;
    endcase
  end

endmodule

// File: rtl/data_sram_if.sv
// MEM-stage bridge to an SRAM-like data bus: one outstanding access, flush-safe.
module data_sram_if
  import data_sram_if_pkg::*;
#(
  parameter bit KSEG_MAP = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [7:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_sel,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        adel,
  output logic        ades,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  state_t      state, nstate;
  logic [7:0]  op_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  sel_q;
  logic        known, mis, accept, capture;
  logic [31:0] align_res;

  assign known  = is_load(mem_op) || is_store(mem_op);
  assign mis    = misaligned(mem_op, mem_addr[1:0]);
  assign accept = (state == S_IDLE) && mem_valid && known && !mis && !flush;

  // Exceptions are gated by reset so all flags read 0 while it is held.
  assign adel = resetn && mem_valid && is_load(mem_op) && mis;
  assign ades = resetn && mem_valid && is_store(mem_op) && mis;

  assign stall = resetn && ((state == S_REQ) || (state == S_WAIT) ||
                            (state == S_CANCEL) || accept);
  assign data_req    = (state == S_REQ);
  assign rdata_valid = (state == S_DONE) && is_load(op_q);

  // Request fields come from the latched copy so they stay stable in REQ.
  assign data_wr    = is_store(op_q);
  assign data_size  = op_size(op_q);
  assign data_wstrb = {sel_q[0], sel_q[1], sel_q[2], sel_q[3]};
  assign data_addr  = (KSEG_MAP && addr_q[31:30] == 2'b10) ? {3'b000, addr_q[28:0]} : addr_q;

  // Replicate store data across the lanes it may land in.
  always_comb begin
    data_wdata = wdata_q;
    case (op_q)
      EXE_SB_OP: data_wdata = {4{wdata_q[7:0]}};
      EXE_SH_OP: data_wdata = {2{wdata_q[15:0]}};
      default:   data_wdata = wdata_q;
    endcase
  end

  load_align u_align (
    .op     (op_q),
    .offset (addr_q[1:0]),
    .raw    (data_rdata),
    .result (align_res)
  );

  // Next-state decode; a flush that coincides with the data beat drops it directly.
  always_comb begin
    nstate  = state;
    capture = 1'b0;
    case (state)
      S_IDLE: if (accept) nstate = S_REQ;
      S_REQ: begin
        if (data_addr_ok) begin
          if (flush)             nstate = data_data_ok ? S_IDLE : S_CANCEL;
          else if (data_data_ok) begin nstate = S_DONE; capture = 1'b1; end
          else                   nstate = S_WAIT;
        end else if (flush) begin
          nstate = S_IDLE;
        end
      end
      S_WAIT: begin
        if (data_data_ok) begin
          if (flush) nstate = S_IDLE;
          else begin nstate = S_DONE; capture = 1'b1; end
        end else if (flush) begin
          nstate = S_CANCEL;
        end
      end
      S_CANCEL: if (data_data_ok) nstate = S_IDLE;
      S_DONE:   nstate = S_IDLE;
      default:  nstate = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= nstate;
  end

  // Latch the MEM-stage request when it is accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
    end else if (accept) begin
      op_q    <= mem_op;
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      sel_q   <= mem_sel;
    end
  end

  // Register the aligned load result on the accepted data beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      rdata <= '0;
    else if (capture) rdata <= align_res;
  end

endmodule

// File: tb/tb_data_sram_if.sv
// Self-checking bench for data_sram_if with a transaction-level reference model.
module tb_data_sram_if;
  import data_sram_if_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid, flush;
  logic [7:0]  mem_op;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_sel;
  logic        stall, rdata_valid, adel, ades;
  logic [31:0] rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_hold = 32'h0;   // last load result the model expects rdata to hold
  logic [31:0] obs_rdata, obs_addr;

  always #5 clk = ~clk;

  data_sram_if #(.KSEG_MAP(1'b1)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sel(mem_sel), .flush(flush),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .adel(adel), .ades(ades),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  // ---------------- reference model ----------------
  function automatic bit m_is_load(input logic [7:0] op);
    return op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_LW_OP;
  endfunction

  function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] raw);
    logic [31:0] b, h;
    int off;
    off = int'(addr % 4);
    b = (raw >> (8 * off)) & 32'hFF;
    h = (raw >> (16 * (off / 2))) & 32'hFFFF;
    case (op)
      EXE_LB_OP:  return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      EXE_LBU_OP: return b;
      EXE_LH_OP:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      EXE_LHU_OP: return h;
      default:    return raw;
    endcase
  endfunction

  function automatic logic [31:0] m_addr(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a <= 32'hBFFF_FFFF) return a & 32'h1FFF_FFFF;
    return a;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] w);
    if (op == EXE_SB_OP) return (w & 32'hFF) * 32'h0101_0101;
    if (op == EXE_SH_OP) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [3:0] m_strb(input logic [3:0] s);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = s[3 - i];
    return r;
  endfunction

  function automatic logic [1:0] m_size(input logic [7:0] op);
    if (op == EXE_LW_OP || op == EXE_SW_OP) return 2'd2;
    if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2'd1;
    return 2'd0;
  endfunction

  // One complete access: addr_ok after a REQ wait cycles, data_ok d cycles after addr_ok.
  task automatic run_access(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] sel, input logic [31:0] raw, input int a, input int d);
    int  done_k;
    bit  ld;
    logic [31:0] exp_r;
    done_k = 2 + a + d;
    ld     = m_is_load(op);
    exp_r  = m_load(op, addr, raw);
    for (int k = 0; k <= done_k; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        mem_valid = 1'b1; mem_op = op; mem_addr = addr; mem_wdata = wd; mem_sel = sel;
      end else begin
        mem_valid = 1'b0; mem_addr = $urandom; mem_wdata = $urandom; mem_sel = 4'($urandom);
      end
      data_addr_ok = (k == 1 + a);
      data_data_ok = (k == 1 + a + d);
      data_rdata   = (k == 1 + a + d) ? raw : $urandom;
      @(negedge clk);
      n_checks++;
      if (stall !== (k < done_k)) begin
        n_fail++; $display("FAIL stall k=%0d op=%h: got %b want %b", k, op, stall, (k < done_k));
      end
      n_checks++;
      if (data_req !== (k >= 1 && k <= 1 + a)) begin
        n_fail++; $display("FAIL data_req k=%0d op=%h: got %b want %b", k, op, data_req, (k >= 1 && k <= 1 + a));
      end
      n_checks++;
      if (rdata_valid !== (k == done_k && ld)) begin
        n_fail++; $display("FAIL rdata_valid k=%0d op=%h: got %b want %b", k, op, rdata_valid, (k == done_k && ld));
      end
      if (k >= 1 && k <= 1 + a) begin
        n_checks++;
        if (data_addr !== m_addr(addr) || data_size !== m_size(op) || data_wr !== !ld) begin
          n_fail++; $display("FAIL req_fields op=%h: addr %h size %0d wr %b want %h %0d %b",
                             op, data_addr, data_size, data_wr, m_addr(addr), m_size(op), !ld);
        end
        obs_addr = data_addr;
        if (!ld) begin
          n_checks++;
          if (data_wdata !== m_wdata(op, wd) || data_wstrb !== m_strb(sel)) begin
            n_fail++; $display("FAIL store_fields op=%h: wdata %h strb %b want %h %b",
                               op, data_wdata, data_wstrb, m_wdata(op, wd), m_strb(sel));
          end
        end
      end
      if (k == done_k && ld) begin
        n_checks++;
        if (rdata !== exp_r) begin
          n_fail++; $display("FAIL rdata op=%h addr=%h raw=%h: got %h want %h", op, addr, raw, rdata, exp_r);
        end
        obs_rdata = rdata;
        exp_hold  = exp_r;
      end
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
  endtask

  task automatic idle_cycle;
    @(posedge clk); #1;
    mem_valid = 1'b0; flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    resetn = 1'b0; flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    mem_valid = 1'b1; mem_op = EXE_LW_OP; mem_addr = 32'h0000_0002; mem_wdata = '0; mem_sel = 4'hF;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({data_req, stall, rdata_valid, adel, ades} !== 5'b0 || rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_outputs: req/stall/rv/adel/ades=%b rdata=%h want 0", {data_req, stall, rdata_valid, adel, ades}, rdata);
    end
    mem_op = EXE_SB_OP; mem_addr = 32'h0000_0001;
    #1;
    n_checks++;
    if (stall !== 1'b0 || data_addr !== 32'h0 || data_wstrb !== 4'h0) begin
      n_fail++; $display("FAIL reset_accept: stall %b addr %h strb %b want 0", stall, data_addr, data_wstrb);
    end
    mem_valid = 1'b0;
    @(negedge clk); resetn = 1'b1;
  endtask

  task automatic test_lb_kseg;
    run_access(EXE_LB_OP, 32'h8000_0003, 32'h0, 4'b0001, 32'h80FF_FF7F, 0, 1);
    n_checks++;
    if (obs_addr !== 32'h0000_0003 || obs_rdata !== 32'hFFFF_FF80) begin
      n_fail++; $display("FAIL lb_kseg: addr %h rdata %h want 00000003 ffffff80", obs_addr, obs_rdata);
    end
    idle_cycle();
  endtask

  task automatic test_sh_store;
    run_access(EXE_SH_OP, 32'h0000_1002, 32'h1234_ABCD, 4'b0011, 32'h0, 1, 1);
    idle_cycle();
  endtask

  task automatic test_misaligned;
    logic [7:0]  ops [3] = '{EXE_LW_OP, EXE_SW_OP, EXE_LHU_OP};
    logic [31:0] ads [3] = '{32'h0000_1002, 32'h0000_2001, 32'hA000_0003};
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_op = ops[t]; mem_addr = ads[t];
        @(negedge clk);
        n_checks++;
        if (adel !== m_is_load(ops[t]) || ades !== !m_is_load(ops[t]) || stall !== 1'b0 || data_req !== 1'b0) begin
          n_fail++; $display("FAIL misaligned op=%h: adel %b ades %b stall %b req %b", ops[t], adel, ades, stall, data_req);
        end
      end
    end
    idle_cycle();
    @(negedge clk);
    n_checks++;
    if (adel !== 1'b0 || ades !== 1'b0) begin
      n_fail++; $display("FAIL exc_clear: adel %b ades %b want 0 0", adel, ades);
    end
  endtask

  task automatic test_same_cycle;
    run_access(EXE_LHU_OP, 32'h0000_0042, 32'h0, 4'b0011, 32'h9876_0000, 0, 0);
    n_checks++;
    if (obs_rdata !== 32'h0000_9876) begin
      n_fail++; $display("FAIL lhu_same_cycle: rdata %h want 00009876", obs_rdata);
    end
  endtask

  task automatic test_flush_wait;
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk); #1;
      mem_valid    = (k == 0);
      mem_op       = EXE_LW_OP; mem_addr = 32'h0000_2000;
      data_addr_ok = (k == 1);
      flush        = (k == 2);
      data_data_ok = (k == 7);
      data_rdata   = 32'hDEAD_BEEF;
      @(negedge clk);
      n_checks++;
      if (stall !== (k <= 7) || rdata_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_wait k=%0d: stall %b rv %b want %b 0", k, stall, rdata_valid, (k <= 7));
      end
    end
    n_checks++;
    if (data_req !== 1'b0 || rdata !== exp_hold) begin
      n_fail++; $display("FAIL cancel_discard: req %b rdata %h want 0 %h", data_req, rdata, exp_hold);
    end
    data_data_ok = 1'b0;
  endtask

  task automatic test_flush_req;
    for (int k = 0; k <= 2; k++) begin
      @(posedge clk); #1;
      mem_valid = (k == 0); mem_op = EXE_SW_OP; mem_addr = 32'h0000_3000;
      flush = (k == 1); data_addr_ok = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (data_req !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_req: req %b stall %b want 0 0", data_req, stall);
    end
    // flush in IDLE must block acceptance
    @(posedge clk); #1; mem_valid = 1'b1; mem_op = EXE_LW_OP; flush = 1'b1;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle: stall %b want 0", stall);
    end
    idle_cycle();
  endtask

  task automatic test_unknown_op;
    @(posedge clk); #1; mem_valid = 1'b1; mem_op = 8'hFF; mem_addr = 32'h0000_0001;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || adel !== 1'b0 || ades !== 1'b0) begin
      n_fail++; $display("FAIL unknown_op: stall %b adel %b ades %b want 0", stall, adel, ades);
    end
    @(posedge clk); #1; mem_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (data_req !== 1'b0) begin
      n_fail++; $display("FAIL unknown_req: data_req %b want 0", data_req);
    end
  endtask

  task automatic test_reset_midflight;
    @(posedge clk); #1; mem_valid = 1'b1; mem_op = EXE_LW_OP; mem_addr = 32'h0000_4000;
    @(posedge clk); #1; mem_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (data_req !== 1'b1) begin
      n_fail++; $display("FAIL midflight_req: data_req %b want 1", data_req);
    end
    #1 resetn = 1'b0;
    #1;
    n_checks++;
    if (data_req !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: req %b stall %b want 0 0", data_req, stall);
    end
    exp_hold = 32'h0;
    @(negedge clk); resetn = 1'b1;
    run_access(EXE_LBU_OP, 32'h0000_5001, 32'h0, 4'h0, 32'h1122_C344, 1, 2);
    idle_cycle();
  endtask

  task automatic test_random;
    logic [7:0] ops [8] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    logic [7:0]  op;
    logic [31:0] addr;
    for (int n = 0; n < 40; n++) begin
      op   = ops[$urandom_range(0, 7)];
      addr = $urandom;
      if (m_size(op) == 2'd1) addr[0] = 1'b0;
      if (m_size(op) == 2'd2) addr[1:0] = 2'b00;
      run_access(op, addr, $urandom, 4'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_lb_kseg();
    test_sh_store();
    test_misaligned();
    test_same_cycle();
    test_flush_wait();
    test_flush_req();
    test_unknown_op();
    test_reset_midflight();
    test_random();
    idle_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_sram_if.md
DATA_SRAM_IF -- requirements
Module: data_sram_if

Interface
REQ-001 Parameter KSEG_MAP, default 1: when 1, the block SHALL clear addr[31:29] on data_addr for kseg0/kseg1 addresses (0x8000_0000-0xBFFF_FFFF); when 0, it SHALL pass the address through unchanged.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 mem_valid  in  1  MEM stage holds a valid load/store.
REQ-005 mem_op  in  8  EXE_*_OP code (LB, LBU, LH, LHU, LW, SB, SH, SW).
REQ-006 mem_addr  in  32  virtual byte address.
REQ-007 mem_wdata  in  32  unaligned store source (rt).
REQ-008 mem_sel  in  4  byte select from upstream; bit3 = byte offset 0, bit0 = offset 3.
REQ-009 flush  in  1  exception/eret flush of the MEM stage.
REQ-010 stall  out  1  freezes the pipeline while an access is outstanding.
REQ-011 rdata  out  32  aligned and extended load result.
REQ-012 rdata_valid  out  1  one-cycle pulse when rdata is valid.
REQ-013 adel / ades  out  1 each  misaligned load / store exception flags.
REQ-014 data_req, data_wr  out  1 each; data_size  out  2; data_addr  out  32; data_wdata  out  32; data_wstrb  out  4  SRAM-like request channel.
REQ-015 data_addr_ok, data_data_ok  in  1 each; data_rdata  in  32  SRAM-like response channel.

Function
REQ-016 A request is misaligned when (LH/LHU/SH and addr[0]) or (LW/SW and addr[1:0]!=0); misalignment SHALL raise adel/ades combinationally while mem_valid=1, issue no bus request, and hold stall=0.
REQ-017 The FSM SHALL have the states IDLE, REQ, WAIT, CANCEL and DONE.
REQ-018 IDLE: mem_valid & aligned & !flush SHALL latch op/addr/wdata/sel and move to REQ; stall SHALL be 1 in that cycle.
REQ-019 REQ: data_req SHALL be 1 with stable request fields until data_addr_ok=1; then the FSM SHALL go to WAIT, or directly to DONE if data_data_ok=1 in the same cycle.
REQ-020 WAIT: on data_data_ok=1 the block SHALL register the aligned result and go to DONE.
REQ-021 DONE: rdata_valid SHALL be 1 for loads only, stall SHALL be 0, and the FSM SHALL return to IDLE the next cycle; latency = 2 cycles + bus wait.
REQ-022 stall SHALL be 1 in REQ, WAIT and CANCEL, and in IDLE when accepting a request; it SHALL be 0 otherwise.
REQ-023 flush in IDLE or REQ before addr_ok SHALL abort to IDLE with data_req dropped the next cycle; flush in REQ coinciding with addr_ok, or in WAIT, SHALL go to CANCEL.
REQ-024 CANCEL SHALL wait for data_data_ok, discard the data, assert no rdata_valid, then go to IDLE.
REQ-025 Load alignment SHALL use little-endian lane k = data_rdata[8k+7:8k]: LB/LBU select lane addr[1:0] with sign/zero extension; LH/LHU select lanes {2*addr[1]+1, 2*addr[1]} with sign/zero extension; LW passes the word through.
REQ-026 Stores: data_wdata SHALL be the byte replicated x4 for SB, the halfword replicated x2 for SH, and the word unchanged for SW; data_wstrb SHALL be the bit-reverse of mem_sel; data_wr SHALL be 1.
REQ-027 data_size SHALL be 0 for byte, 1 for half and 2 for word accesses.
REQ-028 Unknown mem_op with mem_valid=1 SHALL be ignored: no request, stall 0.

Reset
REQ-029 resetn=0 SHALL force the IDLE state immediately and drive data_req, stall, rdata_valid, adel and ades to 0, rdata to 0 and all latched fields to 0; a request in flight at reset is abandoned.

Structure
REQ-030 The EXE_*_OP codes and the FSM state encodings SHALL live in the shared defines package.
REQ-031 The combinational load aligner/extender SHALL be one sub-module, load_align (op, offset, raw -> result).

Verification
REQ-032 LB at addr 0x8000_0003 with data_rdata 0x80FF_FF7F, addr_ok on cycle 1 and data_ok on cycle 3 -> data_addr 0x0000_0003, rdata 0xFFFF_FF80, rdata_valid on cycle 4, stall low on cycle 4.
REQ-033 SH with addr offset 2, wdata 0x1234_ABCD and mem_sel 0011 -> data_wstrb 1100, data_wdata 0xABCD_ABCD, data_size 1, no rdata_valid.
REQ-034 LW at 0x...0002 -> adel=1, data_req never asserted, stall=0.
REQ-035 LHU with addr_ok and data_ok in the same cycle and data_rdata 0x9876_0000 at offset 2 -> FSM goes directly to DONE, rdata 0x0000_9876.
REQ-036 flush during WAIT -> CANCEL; data_ok arrives 5 cycles later -> no rdata_valid, return to IDLE, stall high throughout.
REQ-037 resetn pulsed low during REQ -> data_req=0 asynchronously; after release, the next access completes normally.
